// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out block collector.
package sipo_pkg;

  localparam int unsigned ABS_MAX_W = 64;

  typedef int unsigned lane_cnt_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Magnitude of a sign-extended w-bit sample; the most negative code saturates to 2^(w-1)-1.
  function automatic logic [ABS_MAX_W-1:0] abs_sat(input logic signed [ABS_MAX_W-1:0] x,
                                                   input lane_cnt_t w);
    logic signed [ABS_MAX_W-1:0] lim;
    lim = $signed(ABS_MAX_W'(64'd1 << (w - 1)));
    if (x == -lim) begin
      abs_sat = ABS_MAX_W'(lim - 64'sd1);
    end else if (x < 64'sd0) begin
      abs_sat = ABS_MAX_W'(-x);
    end else begin
      abs_sat = ABS_MAX_W'(x);
    end
  endfunction

endpackage

// File: rtl/sipo_lane_reg.sv
// One assembly lane: W-bit register with load enable and async active-low clear.
module sipo_lane_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_block_collector.sv
// Gathers DEPTH samples into one parallel block with valid/ready on both sides and partial flush.
// Define SIPO_MAXABS_EN to add the max_abs output (largest |sample| of the presented block).
module sipo_block_collector
  import sipo_pkg::*;
#(
  parameter int unsigned BIT_SIZE = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_SIZE-1:0]       in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIT_SIZE*DEPTH-1:0] out_data,
  output logic [CNT_W-1:0]          out_fill,
  output logic [CNT_W-1:0]          fill_count
`ifdef SIPO_MAXABS_EN
  ,
  output logic [BIT_SIZE-1:0]       max_abs
`endif
);

  localparam int unsigned W     = BIT_SIZE;
  localparam int unsigned OUT_W = BIT_SIZE * DEPTH;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               close_blk;
  logic [CNT_W-1:0]   new_cnt;
  logic [CNT_W-1:0]   fill_nxt;
  logic [DEPTH-1:0]   lane_en;
  logic [OUT_W-1:0]   blk_nxt;
  logic [W-1:0]       lane_q [DEPTH];

  // The output register can be refilled in the same cycle it drains.
  assign in_ready  = (state == FILL) || out_ready;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (close_blk) state_nxt = HOLD;
      HOLD: begin
        if (close_blk) begin
          state_nxt = HOLD;
        end else if (out_ready) begin
          state_nxt = FILL;
        end
      end
    endcase
  end

  // Close a block on the DEPTH-th accept, or on flush when at least one sample is pending.
  always_comb begin
    accept    = in_valid & in_ready;
    new_cnt   = fill_count + CNT_W'(accept);
    close_blk = in_ready & ((accept & (fill_count == CNT_W'(DEPTH - 1)))
                            | (flush & (new_cnt != '0)));
    fill_nxt  = close_blk ? '0 : new_cnt;
    lane_en   = '0;
    blk_nxt   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lane_en[k] = accept & (fill_count == CNT_W'(k));
      if (CNT_W'(k) < new_cnt) begin
        blk_nxt[k*W +: W] = lane_en[k] ? in_data : lane_q[k];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_lane
    sipo_lane_reg #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (lane_en[k]),
      .d     (in_data),
      .q     (lane_q[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
      out_data   <= '0;
      out_fill   <= '0;
    end else begin
      fill_count <= fill_nxt;
      if (close_blk) begin
        out_data <= blk_nxt;
        out_fill <= new_cnt;
      end
    end
  end

`ifdef SIPO_MAXABS_EN
  logic [W-1:0] run_max;
  logic [W-1:0] cur_abs;
  logic [W-1:0] merged_max;

  // run_max is zero whenever the assembly buffer is empty, so it merges directly.
  always_comb begin
    cur_abs    = W'(abs_sat(ABS_MAX_W'(signed'(in_data)), W));
    merged_max = run_max;
    if (accept && (cur_abs > run_max)) begin
      merged_max = cur_abs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= '0;
      max_abs <= '0;
    end else if (close_blk) begin
      run_max <= '0;
      max_abs <= merged_max;
    end else if (accept) begin
      run_max <= merged_max;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_block_collector.sv
// Self-checking bench for sipo_block_collector (W=16, N=4): vector table, directed corners, random vs. queue model.
module tb_sipo_block_collector;

  localparam int W = 16;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_fill;
  logic [2:0]  fill_count;
`ifdef SIPO_MAXABS_EN
  logic [15:0] max_abs;
`endif

  int total  = 0;
  int passed = 0;

  sipo_block_collector #(.BIT_SIZE(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_fill   (out_fill),
    .fill_count (fill_count)
`ifdef SIPO_MAXABS_EN
    ,
    .max_abs    (max_abs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        r;
    logic        e_ov;
    logic [63:0] e_data;
    logic [2:0]  e_fill;
    logic [2:0]  e_fc;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic f, input logic r,
                              input logic e_ov, input logic [63:0] e_data, input logic [2:0] e_fill,
                              input logic [2:0] e_fc);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = r;
    t.e_ov = e_ov; t.e_data = e_data; t.e_fill = e_fill; t.e_fc = e_fc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    drive(1'b1, d, 1'b0, 1'b1);
    tick();
  endtask

  function automatic logic [15:0] tabs(input logic [15:0] s);
    if (s == 16'h8000) return 16'h7FFF;
    return s[15] ? 16'(-s) : s;
  endfunction

  // Queue-based model state
  logic [15:0] q [$];
  logic        m_valid;
  logic [63:0] m_data;
  logic [2:0]  m_fill;
  logic [15:0] m_max;

  initial begin
    vt[0]  = mk(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd1);
    vt[1]  = mk(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd2);
    vt[2]  = mk(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd3);
    vt[3]  = mk(1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 64'h0004_0003_0002_0001, 3'd4, 3'd0);
    vt[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd0);
    vt[5]  = mk(1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd1);
    vt[6]  = mk(1'b1, 16'h00BB, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd2);
    vt[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 64'h0000_0000_00BB_00AA, 3'd2, 3'd0);
    vt[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0, 3'd0);
    vt[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 64'h0, 3'd0, 3'd0);
    vt[10] = mk(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd1);
    vt[11] = mk(1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd2);
    vt[12] = mk(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd3);
    vt[13] = mk(1'b1, 16'h0044, 1'b1, 1'b1, 1'b1, 64'h0044_0033_0022_0011, 3'd4, 3'd0);
    vt[14] = mk(1'b1, 16'h0055, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0055, 3'd1, 3'd0);
    vt[15] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 3'd0);

    // Reset values
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_count", 64'(fill_count), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_fill", 64'(out_fill), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].f, vt[i].r);
      tick();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      chk($sformatf("vec%0d_fill_count", i), 64'(fill_count), 64'(vt[i].e_fc));
      if (vt[i].e_ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vt[i].e_data);
        chk($sformatf("vec%0d_out_fill", i), 64'(out_fill), 64'(vt[i].e_fill));
      end
    end

    // Backpressure: a full block held while upstream keeps offering samples
    for (int i = 0; i < 4; i++) send(16'h0A00 + 16'(i));
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    drive(1'b1, 16'h0B00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, 64'h0A03_0A02_0A01_0A00);
      chk("bp_hold_fc", 64'(fill_count), 64'd0);
    end
    send(16'h0B00);
    chk("bp_drain_valid", 64'(out_valid), 64'd0);
    chk("bp_drain_fc", 64'(fill_count), 64'd1);
    for (int i = 1; i < 4; i++) send(16'h0B00 + 16'(i));
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_data", out_data, 64'h0B03_0B02_0B01_0B00);
    chk("bp_b_fill", 64'(out_fill), 64'd4);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();

    // Reset mid-block
    for (int i = 1; i < 4; i++) send(16'h0C00 + 16'(i));
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_fc", 64'(fill_count), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_pulse", 64'(out_valid), 64'd0);
    for (int i = 1; i < 5; i++) send(16'h0D00 + 16'(i));
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", out_data, 64'h0D04_0D03_0D02_0D01);
    chk("post_rst_fill", 64'(out_fill), 64'd4);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();

`ifdef SIPO_MAXABS_EN
    send(16'h0005); send(16'hFFF0); send(16'h8000); send(16'h0010);
    chk("maxabs_sat", 64'(max_abs), 64'h7FFF);
    send(16'h0001); send(16'hFFFD); send(16'h0002); send(16'h0000);
    chk("maxabs_small", 64'(max_abs), 64'd3);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
`endif

    // Randomized traffic against the queue model
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_fill  = '0;
    m_max   = '0;
    for (int c = 0; c < 1500; c++) begin
      logic        v, f, r, rdy;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      drive(v, d, f, r);
      #1;
      rdy = !m_valid || r;
      chk("rnd_in_ready", 64'(in_ready), 64'(rdy));
      if (v && rdy) q.push_back(d);
      if (rdy && (q.size() == N || (f && q.size() > 0))) begin
        m_valid = 1'b1;
        m_data  = '0;
        m_max   = '0;
        foreach (q[i]) begin
          m_data[i*W +: W] = q[i];
          if (tabs(q[i]) > m_max) m_max = tabs(q[i]);
        end
        m_fill = 3'(q.size());
        q.delete();
      end else if (r) begin
        m_valid = 1'b0;
      end
      tick();
      chk("rnd_out_valid", 64'(out_valid), 64'(m_valid));
      chk("rnd_fill_count", 64'(fill_count), 64'(q.size()));
      if (m_valid) begin
        chk("rnd_out_data", out_data, m_data);
        chk("rnd_out_fill", 64'(out_fill), 64'(m_fill));
`ifdef SIPO_MAXABS_EN
        chk("rnd_max_abs", 64'(max_abs), 64'(m_max));
`endif
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
